// File: rtl/gps_signal_synth.sv
// GPS L1 C/A baseband sample synthesizer: carrier and code NCOs, G1/G2 gold
// code generator, navigation bit modulation and 2-bit sign/magnitude I/Q output.
module gps_signal_synth (
  input  logic        mclk,
  input  logic        mclr,
  input  logic        enable,
  input  logic [4:0]  prn_sel,
  input  logic [29:0] carr_fword,
  input  logic [29:0] code_fword,
  input  logic        quad_en,
  input  logic        nav_data_i,
  input  logic        nav_valid_i,
  output logic [1:0]  adc2bit_i,
  output logic [1:0]  adc2bit_q,
  output logic        epoch_o,
  output logic        chip_o,
  output logic        nav_ack_o,
  output logic        nav_underrun_o
);

  // G2 phase-select taps for each PRN, as zero-based stage indices {a, b}.
  function automatic logic [7:0] prn_taps(input logic [4:0] prn);
    logic [7:0] t;
    t = '0;
    case (prn)
      5'd0:  t = {4'd1, 4'd5};  5'd1:  t = {4'd2, 4'd6};  5'd2:  t = {4'd3, 4'd7};  5'd3:  t = {4'd4, 4'd8};
      5'd4:  t = {4'd0, 4'd8};  5'd5:  t = {4'd1, 4'd9};  5'd6:  t = {4'd0, 4'd7};  5'd7:  t = {4'd1, 4'd8};
      5'd8:  t = {4'd2, 4'd9};  5'd9:  t = {4'd1, 4'd2};  5'd10: t = {4'd2, 4'd3};  5'd11: t = {4'd4, 4'd5};
      5'd12: t = {4'd5, 4'd6};  5'd13: t = {4'd6, 4'd7};  5'd14: t = {4'd7, 4'd8};  5'd15: t = {4'd8, 4'd9};
      5'd16: t = {4'd0, 4'd3};  5'd17: t = {4'd1, 4'd4};  5'd18: t = {4'd2, 4'd5};  5'd19: t = {4'd3, 4'd6};
      5'd20: t = {4'd4, 4'd7};  5'd21: t = {4'd5, 4'd8};  5'd22: t = {4'd0, 4'd2};  5'd23: t = {4'd3, 4'd5};
      5'd24: t = {4'd4, 4'd6};  5'd25: t = {4'd5, 4'd7};  5'd26: t = {4'd6, 4'd8};  5'd27: t = {4'd7, 4'd9};
      5'd28: t = {4'd0, 4'd5};  5'd29: t = {4'd1, 4'd6};  5'd30: t = {4'd2, 4'd7};  5'd31: t = {4'd3, 4'd8};
      default: t = '0;
    endcase
    return t;
  endfunction

  logic [29:0] carr_q, carr_d;
  logic [29:0] code_q, code_d;
  logic [9:0]  chip_cnt_q, chip_cnt_d;
  logic [9:0]  g1_q, g1_d;
  logic [9:0]  g2_q, g2_d;
  logic [7:0]  tap_q, tap_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        nav_bit_q, nav_bit_d;
  logic        underrun_q, underrun_d;
  logic        epoch_pend_q, epoch_pend_d;
  logic        ack_pend_q, ack_pend_d;

  logic [1:0]  adc_i_q, adc_q_q;
  logic        epoch_o_q, chip_o_q, ack_o_q, underrun_o_q;

  logic [30:0] code_sum;
  logic [2:0]  oct;
  logic        cos_neg, cos_big, sin_neg, sin_big;
  logic        chip, mod;

  // Pending flags carry an epoch / bit-boundary event from the state update
  // into the output stage, so the pulse lines up with the first sample of chip 0.
  always_comb begin
    carr_d       = carr_q;
    code_d       = code_q;
    chip_cnt_d   = chip_cnt_q;
    g1_d         = g1_q;
    g2_d         = g2_q;
    tap_d        = tap_q;
    bit_cnt_d    = bit_cnt_q;
    nav_bit_d    = nav_bit_q;
    underrun_d   = underrun_q;
    epoch_pend_d = epoch_pend_q;
    ack_pend_d   = ack_pend_q;
    code_sum     = {1'b0, code_q} + {1'b0, code_fword};
    if (enable) begin
      carr_d       = carr_q + carr_fword;
      code_d       = code_sum[29:0];
      epoch_pend_d = 1'b0;
      ack_pend_d   = 1'b0;
      if (code_sum[30]) begin
        if (chip_cnt_q == 10'd1022) begin
          chip_cnt_d   = '0;
          g1_d         = '1;
          g2_d         = '1;
          tap_d        = prn_taps(prn_sel);
          epoch_pend_d = 1'b1;
          if (bit_cnt_q == 5'd19) begin
            bit_cnt_d = '0;
            if (nav_valid_i) begin
              nav_bit_d  = nav_data_i;
              ack_pend_d = 1'b1;
            end else begin
              nav_bit_d  = 1'b0;
              underrun_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else begin
          chip_cnt_d = chip_cnt_q + 10'd1;
          g1_d       = {g1_q[8:0], g1_q[2] ^ g1_q[9]};
          g2_d       = {g2_q[8:0], g2_q[1] ^ g2_q[2] ^ g2_q[5] ^ g2_q[7] ^ g2_q[8] ^ g2_q[9]};
        end
      end
    end
  end

  always_comb begin
    oct     = carr_q[29:27];
    cos_neg = oct[2] ^ oct[1];
    cos_big = ~(oct[1] ^ oct[0]);
    sin_neg = oct[2];
    sin_big = oct[1] ^ oct[0];
    chip    = g1_q[9] ^ g2_q[tap_q[7:4]] ^ g2_q[tap_q[3:0]];
    mod     = chip ^ nav_bit_q;
  end

  always_ff @(posedge mclk) begin
    if (!mclr) begin
      carr_q       <= '0;
      code_q       <= '0;
      chip_cnt_q   <= '0;
      g1_q         <= '1;
      g2_q         <= '1;
      tap_q        <= prn_taps(prn_sel);
      bit_cnt_q    <= '0;
      nav_bit_q    <= 1'b0;
      underrun_q   <= 1'b0;
      epoch_pend_q <= 1'b0;
      ack_pend_q   <= 1'b0;
      adc_i_q      <= '0;
      adc_q_q      <= '0;
      epoch_o_q    <= 1'b0;
      chip_o_q     <= 1'b0;
      ack_o_q      <= 1'b0;
      underrun_o_q <= 1'b0;
    end else begin
      carr_q       <= carr_d;
      code_q       <= code_d;
      chip_cnt_q   <= chip_cnt_d;
      g1_q         <= g1_d;
      g2_q         <= g2_d;
      tap_q        <= tap_d;
      bit_cnt_q    <= bit_cnt_d;
      nav_bit_q    <= nav_bit_d;
      underrun_q   <= underrun_d;
      epoch_pend_q <= epoch_pend_d;
      ack_pend_q   <= ack_pend_d;
      chip_o_q     <= chip;
      underrun_o_q <= underrun_q;
      if (enable) begin
        adc_i_q   <= {mod ^ cos_neg, cos_big};
        adc_q_q   <= quad_en ? {mod ^ sin_neg, sin_big} : 2'b00;
        epoch_o_q <= epoch_pend_q;
        ack_o_q   <= ack_pend_q;
      end else begin
        adc_i_q   <= '0;
        adc_q_q   <= '0;
        epoch_o_q <= 1'b0;
        ack_o_q   <= 1'b0;
      end
    end
  end

  assign adc2bit_i      = adc_i_q;
  assign adc2bit_q      = adc_q_q;
  assign epoch_o        = epoch_o_q;
  assign chip_o         = chip_o_q;
  assign nav_ack_o      = ack_o_q;
  assign nav_underrun_o = underrun_o_q;

endmodule

// File: tb/tb_gps_signal_synth.sv
// Bench for gps_signal_synth: per-cycle scoreboard against a reference model
// built from a precomputed gold-code table, plus directed scenario checks.
module tb_gps_signal_synth;

  logic        mclk = 1'b0;
  logic        mclr, enable, quad_en, nav_data_i, nav_valid_i;
  logic [4:0]  prn_sel;
  logic [29:0] carr_fword, code_fword;
  logic [1:0]  adc2bit_i, adc2bit_q;
  logic        epoch_o, chip_o, nav_ack_o, nav_underrun_o;

  gps_signal_synth dut (
    .mclk(mclk), .mclr(mclr), .enable(enable), .prn_sel(prn_sel),
    .carr_fword(carr_fword), .code_fword(code_fword), .quad_en(quad_en),
    .nav_data_i(nav_data_i), .nav_valid_i(nav_valid_i),
    .adc2bit_i(adc2bit_i), .adc2bit_q(adc2bit_q), .epoch_o(epoch_o),
    .chip_o(chip_o), .nav_ack_o(nav_ack_o), .nav_underrun_o(nav_underrun_o)
  );

  // ---------------- clock / reset ----------------
  always #5 mclk = ~mclk;

  // ---------------- drive values and bookkeeping ----------------
  logic        d_mclr = 1'b0, d_en = 1'b0, d_quad = 1'b0, d_nd = 1'b0, d_nv = 1'b0;
  logic [4:0]  d_prn = '0;
  logic [29:0] d_carr = '0, d_code = '0;
  int          tk = 0;
  int          n_pass = 0, n_chk = 0;
  logic [7:0]  exp_q[$];
  int          ep_cyc[$];
  int          ack_cyc[$];

  // ---------------- reference model ----------------
  int tap_a[32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int tap_b[32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};
  bit gold[32][1023];

  int unsigned m_carr, m_code;
  int          m_chip, m_bit, m_prn;
  bit          m_nav, m_und, m_ep, m_ack;

  task automatic build_gold();
    logic [10:1] g1, g2;
    logic        f1, f2;
    for (int p = 0; p < 32; p++) begin
      g1 = '1;
      g2 = '1;
      for (int c = 0; c < 1023; c++) begin
        gold[p][c] = g1[10] ^ g2[tap_a[p]] ^ g2[tap_b[p]];
        f1 = g1[3] ^ g1[10];
        f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
        g1 = {g1[9:1], f1};
        g2 = {g2[9:1], f2};
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (tick %0d)", name, got, exp, tk);
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    logic [7:0]      e;
    int              oct;
    bit              m, cneg, cbig, sneg, sbig;
    longint unsigned s;
    @(negedge mclk);
    mclr = d_mclr; enable = d_en; prn_sel = d_prn; carr_fword = d_carr;
    code_fword = d_code; quad_en = d_quad; nav_data_i = d_nd; nav_valid_i = d_nv;
    tk++;
    e = '0;
    if (!d_mclr) begin
      m_carr = 0; m_code = 0; m_chip = 0; m_bit = 0; m_prn = int'(d_prn);
      m_nav = 0; m_und = 0; m_ep = 0; m_ack = 0;
    end else begin
      oct  = int'(m_carr >> 27);
      cneg = (oct >= 2 && oct <= 5);
      cbig = (oct == 0 || oct == 3 || oct == 4 || oct == 7);
      sneg = (oct >= 4);
      sbig = (oct == 1 || oct == 2 || oct == 5 || oct == 6);
      m    = gold[m_prn][m_chip] ^ m_nav;
      e[2] = gold[m_prn][m_chip];
      e[0] = m_und;
      if (d_en) begin
        e[7:6] = {m ^ cneg, cbig};
        e[5:4] = d_quad ? {m ^ sneg, sbig} : 2'b00;
        e[3]   = m_ep;
        e[1]   = m_ack;
        m_carr = (m_carr + 32'(d_carr)) & 32'h3FFF_FFFF;
        s      = 64'(m_code) + 64'(d_code);
        m_code = 32'(s & 64'h3FFF_FFFF);
        m_ep   = 0;
        m_ack  = 0;
        if (s >= 64'h4000_0000) begin
          if (m_chip == 1022) begin
            m_chip = 0;
            m_prn  = int'(d_prn);
            m_ep   = 1;
            m_bit  = m_bit + 1;
            if (m_bit == 20) begin
              m_bit = 0;
              if (d_nv) begin m_nav = d_nd; m_ack = 1; end
              else begin m_nav = 0; m_und = 1; end
            end
          end else begin
            m_chip = m_chip + 1;
          end
        end
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic reset_dut();
    d_mclr = 1'b0;
    tick();
    tick();
    d_mclr = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge mclk) begin
    logic [7:0] got, e;
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {adc2bit_i, adc2bit_q, epoch_o, chip_o, nav_ack_o, nav_underrun_o};
      chk("scoreboard", 32'(got), 32'(e));
      if (epoch_o) ep_cyc.push_back(tk);
      if (nav_ack_o) ack_cyc.push_back(tk);
    end
  end

  // ---------------- stimulus ----------------
  logic [9:0] prn1_ref = 10'b1100100000;
  logic [9:0] pat;
  int         t0, guard, k;

  initial begin
    mclr = 1'b0; enable = 1'b0; prn_sel = '0; carr_fword = '0; code_fword = '0;
    quad_en = 1'b0; nav_data_i = 1'b0; nav_valid_i = 1'b0;
    build_gold();

    // PRN 1 chips, zero carrier, epoch period at 16 clocks per chip
    d_prn = 5'd0; d_code = 30'd1 << 26; d_carr = '0; d_quad = 1'b1; d_en = 1'b1;
    reset_dut();
    @(posedge mclk); #2;
    chk("reset_outputs", 32'({adc2bit_i, adc2bit_q, epoch_o, chip_o, nav_ack_o, nav_underrun_o}), 32'd0);
    ep_cyc.delete();
    t0  = tk;
    pat = '0;
    for (int i = 1; i <= 16400; i++) begin
      tick();
      if (i % 16 == 9 && i / 16 < 10) begin
        k = i / 16;
        @(posedge mclk); #2;
        pat = {pat[8:0], chip_o};
        chk("carr0_adc_i", 32'(adc2bit_i), prn1_ref[9 - k] ? 32'd3 : 32'd1);
        chk("carr0_adc_q", 32'(adc2bit_q), prn1_ref[9 - k] ? 32'd2 : 32'd0);
      end
    end
    chk("prn1_chips", 32'(pat), 32'(prn1_ref));
    chk("epoch_count_a", ep_cyc.size(), 1);
    if (ep_cyc.size() > 0) chk("epoch_period", ep_cyc[0] - t0, 16369);

    // Enable gating: a 100-cycle hold stretches the epoch spacing by 100
    d_prn = 5'($urandom); d_code = 30'd1 << 29; d_carr = 30'($urandom);
    reset_dut();
    ep_cyc.delete();
    guard = 0;
    while (ep_cyc.size() < 1 && guard < 5000) begin tick(); guard++; end
    for (int i = 0; i < 500; i++) tick();
    d_en = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    d_en = 1'b1;
    while (ep_cyc.size() < 2 && guard < 10000) begin tick(); guard++; end
    chk("gate_epochs", ep_cyc.size(), 2);
    if (ep_cyc.size() >= 2) chk("gate_spacing", ep_cyc[1] - ep_cyc[0], 2146);

    // Nav handshake on the 20th epoch, with randomized carrier/quad/enable/PRN
    d_code = 30'($urandom_range(32'h3FF0_0000, 32'h3FFF_FFFF));
    d_nv = 1'b1; d_nd = 1'b1;
    reset_dut();
    ep_cyc.delete();
    ack_cyc.delete();
    guard = 0;
    while (ep_cyc.size() < 20 && guard < 25000) begin
      d_en   = ($urandom_range(0, 31) != 0);
      d_quad = 1'($urandom);
      d_carr = 30'($urandom);
      if ($urandom_range(0, 499) == 0) d_prn = 5'($urandom);
      tick();
      guard++;
    end
    d_en = 1'b1;
    chk("nav_epochs", ep_cyc.size(), 20);
    chk("nav_ack_count", ack_cyc.size(), 1);
    if (ack_cyc.size() > 0 && ep_cyc.size() >= 20) chk("nav_ack_at_epoch20", ack_cyc[0], ep_cyc[19]);

    // Underrun at the next bit boundary, sticky until reset
    d_nv = 1'b0;
    guard = 0;
    while (ep_cyc.size() < 40 && guard < 25000) begin
      d_nd   = 1'($urandom);
      d_carr = 30'($urandom);
      tick();
      guard++;
    end
    for (int i = 0; i < 3; i++) tick();
    @(posedge mclk); #2;
    chk("underrun_epochs", ep_cyc.size(), 40);
    chk("underrun_no_ack", ack_cyc.size(), 1);
    chk("underrun_set", 32'(nav_underrun_o), 32'd1);
    d_nv = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    @(posedge mclk); #2;
    chk("underrun_sticky", 32'(nav_underrun_o), 32'd1);
    reset_dut();
    @(posedge mclk); #2;
    chk("underrun_cleared", 32'(nav_underrun_o), 32'd0);

    // Zero code rate: chip sequence frozen, no epochs
    d_code = '0;
    ep_cyc.delete();
    for (int i = 0; i < 300; i++) begin d_carr = 30'($urandom); tick(); end
    chk("code0_no_epoch", ep_cyc.size(), 0);

    // Mid-run reset at chip 500 restarts PRN 1 from chip 0
    d_prn = 5'd0; d_code = 30'd1 << 29; d_carr = 30'($urandom);
    reset_dut();
    for (int i = 0; i < 1000; i++) tick();
    d_mclr = 1'b0;
    tick();
    d_mclr = 1'b1;
    pat = '0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i % 2 == 0) begin
        @(posedge mclk); #2;
        pat = {pat[8:0], chip_o};
      end
    end
    chk("midreset_chips", 32'(pat), 32'(prn1_ref));

    @(posedge mclk); #3;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
